mips_multicycle_ctrl: RTL and testbench
=======================================

# mips_multicycle_ctrl

Moore-style control FSM that sequences the MIPS multicycle datapath (shared instruction/data memory, instruction register, ALU reused for PC increment and branch target). It sits inside the processor core beside the ALU decoder. It takes the opcode from the instruction register and the ALU zero flag, and drives every datapath enable and mux select. A memory-ready handshake stretches memory states for slow memory.

## Interface
- No parameters; opcodes fixed: R-type 000000, lw 100011, sw 101011, beq 000100, addi 001000, j 000010.
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low (0 = reset asserted)
- op  in  6  opcode field from instruction register; stable from DECODE onward
- zero  in  1  ALU zero flag
- mem_ready  in  1  memory completes the current access this cycle
- iord, alusrca, regdst, memtoreg, branch  out  1 each  datapath mux selects / branch qualifier
- irwrite, pcwrite, memwrite, regwrite  out  1 each  write enables
- pcen  out  1  PC load enable = pcwrite | (branch & zero)
- alusrcb, pcsrc, aluop  out  2 each  ALU-B select, next-PC select, ALU-decoder op
- state  out  4  current state encoding, for debug
- illegal  out  1  sticky: unsupported opcode decoded

## Operation
- States and encoding: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, RTYPEEX=6, RTYPEWB=7, BEQEX=8, ADDIEX=9, ADDIWB=10, JEX=11, TRAP=12. Codes 13-15 are unreachable; if entered, go to FETCH on the next edge.
- Outputs depend on state only, except the mem_ready gating and pcen. Any output not listed for a state is 0.
  - FETCH: alusrcb=01. irwrite=pcwrite=mem_ready.
  - DECODE: alusrcb=11.
  - MEMADR: alusrca=1, alusrcb=10.
  - MEMRD: iord=1.
  - MEMWB: memtoreg=1, regwrite=1.
  - MEMWR: iord=1, memwrite=1. memwrite is held for the whole wait.
  - RTYPEEX: alusrca=1, aluop=10.
  - RTYPEWB: regdst=1, regwrite=1.
  - BEQEX: alusrca=1, aluop=01, pcsrc=01, branch=1.
  - ADDIEX: alusrca=1, alusrcb=10.
  - ADDIWB: regwrite=1.
  - JEX: pcsrc=10, pcwrite=1.
  - TRAP: all 0.
- Transitions:
  - FETCH→DECODE when mem_ready, else stay.
  - DECODE by op: lw/sw→MEMADR, R→RTYPEEX, beq→BEQEX, addi→ADDIEX, j→JEX, other→TRAP.
  - MEMADR→MEMRD (lw) or MEMWR (sw); op is re-examined here.
  - MEMRD→MEMWB when mem_ready, else stay.
  - MEMWR→FETCH when mem_ready, else stay.
  - MEMWB, RTYPEWB, ADDIWB, BEQEX, JEX→FETCH.
  - RTYPEEX→RTYPEWB; ADDIEX→ADDIWB.
  - TRAP→TRAP until reset.
- illegal is set on the DECODE→TRAP edge and stays 1 until reset.

## Timing
- State register updates on the rising clk edge. All outputs are combinational from the registered state plus zero/mem_ready; no output register.
- While reset=0:
  - state=FETCH immediately (asynchronous) and illegal=0.
  - irwrite, pcwrite, memwrite, regwrite and pcen are forced to 0.
  - Mux selects show FETCH values (alusrcb=01, all others 0).
- Reset mid-instruction aborts the instruction with no partial write.
- First FETCH completes on the first rising edge after reset deasserts with mem_ready=1.
- Cycles per instruction with mem_ready tied 1: lw 5, sw 4, R 4, addi 4, beq 3, j 3. Each mem_ready=0 cycle in FETCH/MEMRD/MEMWR adds exactly one cycle.
- pcen follows zero combinationally in BEQEX. A taken beq loads the PC at the BEQEX→FETCH edge.

## Test plan
- lw, mem_ready=1: op=100011 after reset. state goes 0,1,2,3,4,0. regwrite=1 and memtoreg=1 only in state 4. irwrite=1 only in state 0.
- sw with memory stall: op=101011, mem_ready=0 for 3 cycles in MEMWR. state is 5 for 4 cycles with memwrite=1 throughout, then 0. regwrite stays 0.
- beq taken vs not: op=000100.
  - zero=1: pcen=1 in BEQEX.
  - zero=0: pcen=0.
  - Both return to FETCH after 3 cycles.
- j and FETCH stall: mem_ready=0 for 2 cycles in FETCH. irwrite=pcwrite=0 while stalled. Then DECODE, then JEX with pcsrc=10 and pcen=1.
- Illegal opcode: op=111111. DECODE→TRAP (state=12), illegal=1. All enables stay 0 for 10+ cycles. Assert reset: state=0, illegal=0.
- Reset mid-instruction: assert reset asynchronously in RTYPEWB between edges. regwrite drops to 0 at once, state=0. After release, a normal R-type takes 4 cycles.

Source files
------------

// File: rtl/mips_multicycle_ctrl.sv
// rtl/mips_multicycle_ctrl.sv - Moore control FSM for the MIPS multicycle datapath
module mips_multicycle_ctrl (
   input  logic       clk,
   input  logic       reset,
   input  logic [5:0] op,
   input  logic       zero,
   input  logic       mem_ready,
   output logic       iord,
   output logic       alusrca,
   output logic       regdst,
   output logic       memtoreg,
   output logic       branch,
   output logic       irwrite,
   output logic       pcwrite,
   output logic       memwrite,
   output logic       regwrite,
   output logic       pcen,
   output logic [1:0] alusrcb,
   output logic [1:0] pcsrc,
   output logic [1:0] aluop,
   output logic [3:0] state,
   output logic       illegal
);

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_J     = 6'b000010;

   typedef enum logic [3:0] {
      FETCH   = 4'd0,
      DECODE  = 4'd1,
      MEMADR  = 4'd2,
      MEMRD   = 4'd3,
      MEMWB   = 4'd4,
      MEMWR   = 4'd5,
      RTYPEEX = 4'd6,
      RTYPEWB = 4'd7,
      BEQEX   = 4'd8,
      ADDIEX  = 4'd9,
      ADDIWB  = 4'd10,
      JEX     = 4'd11,
      TRAP    = 4'd12
   } state_t;

   state_t state_q;
   logic   illegal_q;
   logic   ir_w, pc_w, mem_w, reg_w;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= FETCH;
         illegal_q <= 1'b0;
      end else begin
         case (state_q)
            FETCH:   if (mem_ready) state_q <= DECODE;
            DECODE: begin
               case (op)
                  OP_LW, OP_SW: state_q <= MEMADR;
                  OP_RTYPE:     state_q <= RTYPEEX;
                  OP_BEQ:       state_q <= BEQEX;
                  OP_ADDI:      state_q <= ADDIEX;
                  OP_J:         state_q <= JEX;
                  default: begin
                     state_q   <= TRAP;
                     illegal_q <= 1'b1;
                  end
               endcase
            end
            MEMADR:  state_q <= (op == OP_SW) ? MEMWR : MEMRD;
            MEMRD:   if (mem_ready) state_q <= MEMWB;
            MEMWR:   if (mem_ready) state_q <= FETCH;
            RTYPEEX: state_q <= RTYPEWB;
            ADDIEX:  state_q <= ADDIWB;
            MEMWB, RTYPEWB, ADDIWB, BEQEX, JEX: state_q <= FETCH;
            TRAP:    state_q <= TRAP;
            default: state_q <= FETCH;
         endcase
      end
   end

   always_comb begin
      iord     = 1'b0;
      alusrca  = 1'b0;
      regdst   = 1'b0;
      memtoreg = 1'b0;
      branch   = 1'b0;
      ir_w     = 1'b0;
      pc_w     = 1'b0;
      mem_w    = 1'b0;
      reg_w    = 1'b0;
      alusrcb  = 2'b00;
      pcsrc    = 2'b00;
      aluop    = 2'b00;
      case (state_q)
         FETCH: begin
            alusrcb = 2'b01;
            ir_w    = mem_ready;
            pc_w    = mem_ready;
         end
         DECODE:  alusrcb = 2'b11;
         MEMADR: begin
            alusrca = 1'b1;
            alusrcb = 2'b10;
         end
         MEMRD:   iord = 1'b1;
         MEMWB: begin
            memtoreg = 1'b1;
            reg_w    = 1'b1;
         end
         MEMWR: begin
            iord  = 1'b1;
            mem_w = 1'b1;
         end
         RTYPEEX: begin
            alusrca = 1'b1;
            aluop   = 2'b10;
         end
         RTYPEWB: begin
            regdst = 1'b1;
            reg_w  = 1'b1;
         end
         BEQEX: begin
            alusrca = 1'b1;
            aluop   = 2'b01;
            pcsrc   = 2'b01;
            branch  = 1'b1;
         end
         ADDIEX: begin
            alusrca = 1'b1;
            alusrcb = 2'b10;
         end
         ADDIWB:  reg_w = 1'b1;
         JEX: begin
            pcsrc = 2'b10;
            pc_w  = 1'b1;
         end
         default: ;
      endcase
   end

   // Write enables are gated by reset so an aborted instruction never commits.
   assign irwrite  = ir_w  & reset;
   assign pcwrite  = pc_w  & reset;
   assign memwrite = mem_w & reset;
   assign regwrite = reg_w & reset;
   assign pcen     = (pc_w | (branch & zero)) & reset;
   assign state    = state_q;
   assign illegal  = illegal_q;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// tb/tb_mips_multicycle_ctrl.sv - directed-vector bench for mips_multicycle_ctrl
module tb_mips_multicycle_ctrl;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic [5:0] op = 6'b0;
   logic       zero = 1'b0;
   logic       mem_ready = 1'b1;
   logic       iord, alusrca, regdst, memtoreg, branch;
   logic       irwrite, pcwrite, memwrite, regwrite, pcen;
   logic [1:0] alusrcb, pcsrc, aluop;
   logic [3:0] state;
   logic       illegal;
   logic [4:0] en_vec;
   int         vectors = 0;
   int         miscompares = 0;

   always #5 clk = ~clk;

   mips_multicycle_ctrl dut (
      .clk(clk), .reset(reset), .op(op), .zero(zero), .mem_ready(mem_ready),
      .iord(iord), .alusrca(alusrca), .regdst(regdst), .memtoreg(memtoreg),
      .branch(branch), .irwrite(irwrite), .pcwrite(pcwrite), .memwrite(memwrite),
      .regwrite(regwrite), .pcen(pcen), .alusrcb(alusrcb), .pcsrc(pcsrc),
      .aluop(aluop), .state(state), .illegal(illegal)
   );

   assign en_vec = {irwrite, pcwrite, memwrite, regwrite, pcen};

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   // Called on a negedge; mem_ready applies to the observed outputs and the next edge.
   task automatic step(input string tag, input logic [3:0] st, input logic [4:0] en,
                       input logic mr);
      mem_ready = mr;
      #1;
      check({tag, "_state"}, {28'd0, state}, {28'd0, st});
      check({tag, "_en"}, {27'd0, en_vec}, {27'd0, en});
      @(negedge clk);
   endtask

   initial begin
      @(negedge clk);
      #1;
      check("rst_state", {28'd0, state}, 32'd0);
      check("rst_illegal", {31'd0, illegal}, 32'd0);
      check("rst_en", {27'd0, en_vec}, 32'd0);
      check("rst_alusrcb", {30'd0, alusrcb}, 32'd1);
      @(negedge clk);
      reset = 1'b1;

      op = 6'b100011;
      step("lw_f", 4'd0, 5'b11001, 1'b1);
      step("lw_d", 4'd1, 5'b00000, 1'b1);
      step("lw_a", 4'd2, 5'b00000, 1'b1);
      step("lw_r", 4'd3, 5'b00000, 1'b1);
      #1 check("lw_memtoreg", {31'd0, memtoreg}, 32'd1);
      step("lw_wb", 4'd4, 5'b00010, 1'b1);

      op = 6'b101011;
      step("sw_f", 4'd0, 5'b11001, 1'b1);
      step("sw_d", 4'd1, 5'b00000, 1'b1);
      step("sw_a", 4'd2, 5'b00000, 1'b1);
      for (int i = 0; i < 3; i++) step("sw_wait", 4'd5, 5'b00100, 1'b0);
      step("sw_wr", 4'd5, 5'b00100, 1'b1);

      op = 6'b000100;
      zero = 1'b1;
      step("beqt_f", 4'd0, 5'b11001, 1'b1);
      step("beqt_d", 4'd1, 5'b00000, 1'b1);
      #1 check("beqt_pcsrc", {30'd0, pcsrc}, 32'd1);
      step("beqt_ex", 4'd8, 5'b00001, 1'b1);
      zero = 1'b0;
      step("beqn_f", 4'd0, 5'b11001, 1'b1);
      step("beqn_d", 4'd1, 5'b00000, 1'b1);
      step("beqn_ex", 4'd8, 5'b00000, 1'b1);

      op = 6'b000010;
      step("j_stall0", 4'd0, 5'b00000, 1'b0);
      step("j_stall1", 4'd0, 5'b00000, 1'b0);
      step("j_f", 4'd0, 5'b11001, 1'b1);
      step("j_d", 4'd1, 5'b00000, 1'b1);
      #1 check("j_pcsrc", {30'd0, pcsrc}, 32'd2);
      step("j_ex", 4'd11, 5'b01001, 1'b1);

      op = 6'b001000;
      step("addi_f", 4'd0, 5'b11001, 1'b1);
      step("addi_d", 4'd1, 5'b00000, 1'b1);
      step("addi_ex", 4'd9, 5'b00000, 1'b1);
      step("addi_wb", 4'd10, 5'b00010, 1'b1);

      op = 6'b000000;
      step("r_f", 4'd0, 5'b11001, 1'b1);
      step("r_d", 4'd1, 5'b00000, 1'b1);
      step("r_ex", 4'd6, 5'b00000, 1'b1);
      #1 check("r_wb_state", {28'd0, state}, 32'd7);
      check("r_wb_regwrite", {31'd0, regwrite}, 32'd1);
      #2 reset = 1'b0;
      #1 check("midrst_state", {28'd0, state}, 32'd0);
      check("midrst_en", {27'd0, en_vec}, 32'd0);
      @(negedge clk);
      reset = 1'b1;
      step("r2_f", 4'd0, 5'b11001, 1'b1);
      step("r2_d", 4'd1, 5'b00000, 1'b1);
      step("r2_ex", 4'd6, 5'b00000, 1'b1);
      step("r2_wb", 4'd7, 5'b00010, 1'b1);
      check("legal_illegal", {31'd0, illegal}, 32'd0);

      op = 6'b111111;
      step("ill_f", 4'd0, 5'b11001, 1'b1);
      step("ill_d", 4'd1, 5'b00000, 1'b1);
      for (int i = 0; i < 10; i++) begin
         #1 check("ill_flag", {31'd0, illegal}, 32'd1);
         step("ill_trap", 4'd12, 5'b00000, 1'b1);
      end
      reset = 1'b0;
      #1 check("ill_rst_state", {28'd0, state}, 32'd0);
      check("ill_rst_flag", {31'd0, illegal}, 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
